// File: rtl/weight_pkg.sv
// Shared types and defaults for the weight RAM write path.
// WEIGHT_CHECKSUM_EN adds a 16-bit running checksum of the loaded words.
package weight_pkg;

    localparam int WEIGHT_W_DEF = 12;
    localparam int ADDR_W_DEF   = 10;
    localparam int DEPTH_DEF    = 1024;
    localparam int CKSUM_W      = 16;

`ifdef WEIGHT_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/weight_addr_gen.sv
// Loadable wrapping RAM address pointer plus the burst word counter.
// Flags the transfer that completes the (depth-clamped) burst.
module weight_addr_gen
    import weight_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   num_words,
    input  logic              step,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W:0]   count,
    output logic              last
);

    localparam logic [ADDR_W:0]   DepthL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   OneC   = 1;
    localparam logic [ADDR_W-1:0] OneA   = 1;

    logic [ADDR_W:0] len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            len   <= '0;
        end else if (load) begin
            ptr   <= base;
            count <= '0;
            len   <= (num_words > DepthL) ? DepthL : num_words;
        end else if (step) begin
            // Pointer wraps naturally at 2**ADDR_W.
            ptr   <= ptr + OneA;
            count <= count + OneC;
        end
    end

    assign last = ((count + OneC) == len);

endmodule

// File: rtl/weight_write_ctrl.sv
// Streams weights from a valid/ready source into the weight RAM write port.
// Optional WEIGHT_CHECKSUM_EN adds a 16-bit modular sum of accepted words.
module weight_write_ctrl
    import weight_pkg::*;
#(
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     num_words,
    input  logic                in_valid,
    input  logic [WEIGHT_W-1:0] in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WEIGHT_W-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     words_written
`ifdef WEIGHT_CHECKSUM_EN
    ,
    output logic [CKSUM_W-1:0]  checksum
`endif
);

    state_t            state;
    logic              load;
    logic              xfer;
    logic              last;
    logic [ADDR_W-1:0] ptr;

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign load     = start && (state == IDLE);
    assign xfer     = in_valid && (state == LOAD);

    weight_addr_gen #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .base     (base_addr),
        .num_words(num_words),
        .step     (xfer),
        .ptr      (ptr),
        .count    (words_written),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= in_data;
                        // done lines up with the final word's write strobe.
                        if (last) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (load) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + CKSUM_W'(in_data);
        end
    end
`endif

endmodule

// File: tb/tb_weight_write_ctrl.sv
// Directed and randomized checks of weight_write_ctrl against a burst-level model.
// Build with +define+WEIGHT_CHECKSUM_EN to also exercise the checksum output.
module tb_weight_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] num_words;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic [10:0] words_written;
`ifdef WEIGHT_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;

    // Reference model: burst bookkeeping in plain integers.
    bit          m_load, m_fin;
    int          m_ptr, m_cnt, m_len;
    logic [15:0] m_sum;
    bit          exp_wr, exp_done;
    int          exp_addr, exp_data;

    always #5 clk = ~clk;

    weight_write_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
`ifdef WEIGHT_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_fin = 0;
        m_ptr = 0; m_cnt = 0; m_len = 0;
        m_sum = 16'h0;
        exp_wr = 0; exp_done = 0;
        exp_addr = 0; exp_data = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        exp_wr = 0;
        exp_done = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (m_load) begin
            if (in_valid) begin
                exp_wr = 1;
                exp_addr = m_ptr;
                exp_data = int'(in_data);
                m_ptr = (m_ptr + 1) % 1024;
                m_cnt++;
                m_sum = m_sum + 16'(in_data);
                if (m_cnt == m_len) begin
                    m_load = 0;
                    m_fin = 1;
                    exp_done = 1;
                end
            end
        end else if (start) begin
            m_ptr = int'(base_addr);
            m_len = (int'(num_words) > 1024) ? 1024 : int'(num_words);
            m_cnt = 0;
            m_sum = 16'h0;
            if (m_len == 0) begin
                m_fin = 1;
                exp_done = 1;
            end else begin
                m_load = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("wr_en", int'(wr_en), int'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", int'(wr_addr), exp_addr);
            chk("wr_data", int'(wr_data), exp_data);
        end
        if (wr_en) wr_seen++;
        chk("done", int'(done), int'(exp_done));
        chk("words_written", int'(words_written), m_cnt);
        chk("in_ready", int'(in_ready), int'(m_load));
        chk("busy", int'(busy), int'(m_load));
`ifdef WEIGHT_CHECKSUM_EN
        if (exp_done) chk("checksum", int'(checksum), int'(m_sum));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_start(input int base, input int num);
        base_addr = 10'(base);
        num_words = 11'(num);
        in_valid = 0;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic feed(input int d, input bit v);
        in_data = 12'(d);
        in_valid = v;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) feed(0, 0);
    endtask

    initial begin
        int w0;
        int guard;
        rst = 1; start = 0; base_addr = '0; num_words = '0;
        in_valid = 0; in_data = '0;
        model_reset();
        #12;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_words", int'(words_written), 0);
        @(negedge clk);
        rst = 0;
        idle(2);

        // Basic burst
        do_start(0, 4);
        for (int i = 1; i <= 4; i++) feed(i, 1);
        chk("basic_done", int'(done), 1);
        chk("basic_words", int'(words_written), 4);
        chk("basic_last_addr", int'(wr_addr), 3);
        idle(2);

        // Backpressure gaps
        w0 = wr_seen;
        do_start(40, 3);
        feed(12'h111, 1); feed(12'h0AA, 0);
        feed(12'h222, 1); feed(12'h0BB, 0);
        feed(12'h333, 1);
        idle(2);
        chk("gaps_writes", wr_seen - w0, 3);

        // Wrap past the top of the RAM
        do_start(1022, 4);
        for (int i = 0; i < 4; i++) feed(12'h700 + i, 1);
        chk("wrap_addr", int'(wr_addr), 1);
        idle(2);

        // Length clamped to depth, extra words refused
        w0 = wr_seen;
        do_start(7, 2000);
        for (int i = 0; i < 1030; i++) feed(int'($urandom_range(0, 4095)), 1);
        chk("clamp_writes", wr_seen - w0, 1024);
        chk("clamp_words", int'(words_written), 1024);
        idle(2);

        // Zero length
        w0 = wr_seen;
        do_start(5, 0);
        chk("zero_done", int'(done), 1);
        idle(2);
        chk("zero_writes", wr_seen - w0, 0);

        // Start pulse mid-burst is ignored
        do_start(100, 3);
        feed(12'h123, 1);
        base_addr = 10'd500; num_words = 11'd7; start = 1;
        feed(12'h456, 1);
        start = 0;
        chk("ign_start_words", int'(words_written), 2);
        chk("ign_start_addr", int'(wr_addr), 101);
        feed(12'h789, 1);
        idle(2);

        // Reset mid-burst
        do_start(200, 5);
        feed(12'hABC, 1); feed(12'hDEF, 1);
        rst = 1;
        #1;
        chk("mid_rst_wr_en", int'(wr_en), 0);
        chk("mid_rst_addr", int'(wr_addr), 0);
        chk("mid_rst_data", int'(wr_data), 0);
        chk("mid_rst_words", int'(words_written), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_done", int'(done), 0);
        model_reset();
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        idle(1);
        do_start(10, 1);
        feed(12'h5A5, 1);
        chk("post_rst_addr", int'(wr_addr), 10);
        idle(2);

`ifdef WEIGHT_CHECKSUM_EN
        do_start(0, 3);
        feed(12'hFFF, 1); feed(12'h001, 1); feed(12'h800, 1);
        chk("cksum_done", int'(done), 1);
        chk("cksum_value", int'(checksum), 16'h1800);
        idle(2);
`endif

        // Randomized bursts with random valid gaps and stray starts
        for (int b = 0; b < 6; b++) begin
            do_start(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)));
            guard = 0;
            while ((m_load || m_fin) && guard < 400) begin
                start = ($urandom_range(0, 15) == 0);
                base_addr = 10'($urandom_range(0, 1023));
                num_words = 11'($urandom_range(0, 2047));
                feed(int'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)));
                guard++;
            end
            start = 0;
            chk("rand_burst_bound", int'(guard < 400), 1);
            idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
